adder_bist: RTL and testbench



---
 rtl/adder_bist_pkg.sv | 21 ++
 rtl/bist_lfsr.sv | 32 +++
 rtl/adder_bist.sv | 132 +++++++++++++
 tb/tb_adder_bist.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_bist_pkg.sv
// Shared types and constants for the adder BIST initiator and its LFSR.
package adder_bist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int unsigned LFSR_W    = 32;
    localparam int unsigned ERR_W     = 8;
    localparam int unsigned CNT_W     = 16;
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    // One right-shifting Galois step: feedback from bit 0 is XORed into the tap mask.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
        return (q >> 1) ^ (q[0] ? LFSR_POLY : LFSR_W'(0));
    endfunction

endpackage

// File: rtl/bist_lfsr.sv
// 32-bit Galois LFSR with synchronous load/step; an all-zero seed is replaced by 1
// so the register can never lock up. Only the low OUT_W bits are exposed.
module bist_lfsr
    import adder_bist_pkg::*;
#(
    parameter int unsigned OUT_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [31:0]       seed,
    input  logic              step,
    output logic [OUT_W-1:0]  q
);

    logic [LFSR_W-1:0] state;
    logic [LFSR_W-1:0] seed_c;

    assign seed_c = (seed == '0) ? LFSR_W'(1) : seed;
    assign q      = state[OUT_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= seed_c;
        end else if (load) begin
            state <= seed_c;
        end else if (step) begin
            state <= lfsr_next(state);
        end
    end

endmodule

// File: rtl/adder_bist.sv
// BIST initiator for the ripple adder: drives LFSR vectors, checks {c_out,sum}
// against a golden sum and reports pass/err_count. Optional first-failure capture
// is enabled by defining ADDER_BIST_FIRST_FAIL_EN.
module adder_bist
    import adder_bist_pkg::*;
#(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned NUM_VECTORS = 16,
    parameter logic [31:0] SEED        = 32'hACE1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
`ifdef ADDER_BIST_FIRST_FAIL_EN
    output logic              fail_valid,
    output logic [WIDTH-1:0]  fail_a,
    output logic [WIDTH-1:0]  fail_b,
    output logic              fail_cin,
`endif
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic [WIDTH-1:0]  a,
    output logic [WIDTH-1:0]  b,
    output logic              c_in,
    input  logic              c_out,
    input  logic [WIDTH-1:0]  sum
);

    localparam int unsigned VEC_W = 2 * WIDTH + 1;

    state_t             state;
    logic [CNT_W-1:0]   vec_cnt;
    logic [VEC_W-1:0]   lfsr_q;
    logic               lfsr_load_c;
    logic               lfsr_step_c;
    logic [WIDTH:0]     golden_c;
    logic               mismatch_c;
    logic               last_vec_c;

    assign lfsr_load_c = (state == IDLE) && start;
    assign lfsr_step_c = (state == CHECK);

    bist_lfsr #(
        .OUT_W (VEC_W)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (lfsr_load_c),
        .seed  (SEED),
        .step  (lfsr_step_c),
        .q     (lfsr_q)
    );

    // Operands are held in registers, so the adder has all of CHECK to settle.
    assign golden_c   = (WIDTH+1)'(a) + (WIDTH+1)'(b) + (WIDTH+1)'(c_in);
    assign mismatch_c = ({c_out, sum} != golden_c);
    assign last_vec_c = ((vec_cnt + CNT_W'(1)) == CNT_W'(NUM_VECTORS));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            vec_cnt   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            a         <= '0;
            b         <= '0;
            c_in      <= 1'b0;
`ifdef ADDER_BIST_FIRST_FAIL_EN
            fail_valid <= 1'b0;
            fail_a     <= '0;
            fail_b     <= '0;
            fail_cin   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= DRIVE;
                        busy      <= 1'b1;
                        pass      <= 1'b0;
                        err_count <= '0;
                        vec_cnt   <= '0;
`ifdef ADDER_BIST_FIRST_FAIL_EN
                        fail_valid <= 1'b0;
                        fail_a     <= '0;
                        fail_b     <= '0;
                        fail_cin   <= 1'b0;
`endif
                    end
                end
                DRIVE: begin
                    a     <= lfsr_q[WIDTH-1:0];
                    b     <= lfsr_q[2*WIDTH-1:WIDTH];
                    c_in  <= lfsr_q[2*WIDTH];
                    state <= CHECK;
                end
                CHECK: begin
                    if (mismatch_c && (err_count != '1)) begin
                        err_count <= err_count + ERR_W'(1);
                    end
`ifdef ADDER_BIST_FIRST_FAIL_EN
                    if (mismatch_c && !fail_valid) begin
                        fail_valid <= 1'b1;
                        fail_a     <= a;
                        fail_b     <= b;
                        fail_cin   <= c_in;
                    end
`endif
                    vec_cnt <= vec_cnt + CNT_W'(1);
                    if (last_vec_c) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state <= DRIVE;
                    end
                end
                DONE: begin
                    pass  <= (err_count == '0);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_bist.sv
// Scoreboard bench for adder_bist: a behavioural adder (with an injectable +1 fault)
// closes the loop; expected vectors and run results are queued at each accepted start.
module tb_adder_bist;

    localparam int unsigned W  = 4;
    localparam int unsigned N  = 16;
    localparam int unsigned N2 = 300;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
    } vec_t;

    typedef struct {
        int unsigned cyc;
        logic [7:0]  err;
    } res_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         start2 = 1'b0;
    logic         fault = 1'b0;

    logic         busy, done, pass, c_in, c_out;
    logic [7:0]   err_count;
    logic [W-1:0] a, b, sum;
    logic         busy2, done2, pass2, c_in2, c_out2;
    logic [7:0]   err2;
    logic [W-1:0] a2, b2, sum2;
`ifdef ADDER_BIST_FIRST_FAIL_EN
    logic         fail_valid, fail_cin, fail_valid2, fail_cin2;
    logic [W-1:0] fail_a, fail_b, fail_a2, fail_b2;
`endif

    int unsigned  n_cmp = 0;
    int unsigned  n_bad = 0;
    int unsigned  cyc = 0;
    int unsigned  done_cnt = 0;
    bit           in_check = 1'b0;
    bit           pass_pending = 1'b0;
    logic         exp_pass;
    vec_t         vq[$];
    res_t         rq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural adders, optionally off by one.
    assign {c_out, sum}   = {1'b0, a}  + {1'b0, b}  + {{W{1'b0}}, c_in}  + {{W{1'b0}}, fault};
    assign {c_out2, sum2} = {1'b0, a2} + {1'b0, b2} + {{W{1'b0}}, c_in2} + {{W{1'b0}}, fault};

    adder_bist #(.WIDTH(W), .NUM_VECTORS(N), .SEED(32'hACE1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
`ifdef ADDER_BIST_FIRST_FAIL_EN
        .fail_valid(fail_valid), .fail_a(fail_a), .fail_b(fail_b), .fail_cin(fail_cin),
`endif
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .a(a), .b(b), .c_in(c_in), .c_out(c_out), .sum(sum)
    );

    adder_bist #(.WIDTH(W), .NUM_VECTORS(N2), .SEED(32'hACE1)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2),
`ifdef ADDER_BIST_FIRST_FAIL_EN
        .fail_valid(fail_valid2), .fail_a(fail_a2), .fail_b(fail_b2), .fail_cin(fail_cin2),
`endif
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
        .a(a2), .b(b2), .c_in(c_in2), .c_out(c_out2), .sum(sum2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model_step(input logic [31:0] s);
        logic [31:0] r;
        r = {1'b0, s[31:1]};
        if (s[0]) r = r ^ 32'h8020_0003;
        return r;
    endfunction

    // Queue one run's vectors and result; k is the cycle count just after the start edge.
    task automatic push_run(input int unsigned k, input logic [7:0] exp_err);
        logic [31:0] s;
        vec_t        v;
        s = 32'hACE1;
        for (int i = 0; i < int'(N); i++) begin
            v.a   = s[3:0];
            v.b   = s[7:4];
            v.cin = s[8];
            vq.push_back(v);
            s = model_step(s);
        end
        rq.push_back('{cyc: k + 2 * N, err: exp_err});
    endtask

    task automatic kick(input logic [7:0] exp_err);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        push_run(cyc, exp_err);
    endtask

    task automatic wait_idle(input int unsigned budget);
        int unsigned n;
        n = 0;
        while ((rq.size() != 0 || pass_pending) && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (rq.size() != 0 || pass_pending) begin
            check("run_timeout", 32'd1, 32'd0);
            rq.delete();
            pass_pending = 1'b0;
        end
        check("vectors_drained", vq.size(), 32'd0);
        vq.delete();
        @(negedge clk);
    endtask

    // Monitor: busy cycles alternate DRIVE/CHECK; operands are compared in CHECK.
    always @(negedge clk) begin
        vec_t v;
        res_t r;
        if (busy) begin
            if (in_check) begin
                if (vq.size() == 0) begin
                    check("unexpected_vector", 32'd1, 32'd0);
                end else begin
                    v = vq.pop_front();
                    check("vec_a", a, v.a);
                    check("vec_b", b, v.b);
                    check("vec_cin", c_in, v.cin);
                end
            end
            in_check = !in_check;
        end else begin
            in_check = 1'b0;
        end
        if (done) begin
            done_cnt++;
            if (rq.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                r = rq.pop_front();
                check("done_cycle", cyc, r.cyc);
                check("err_count", err_count, r.err);
                check("busy_at_done", busy, 1'b0);
                exp_pass     = (r.err == 8'd0);
                pass_pending = 1'b1;
            end
        end else if (pass_pending) begin
            check("pass", pass, exp_pass);
            pass_pending = 1'b0;
        end
    end

    initial begin
        int unsigned d0;
        int unsigned n;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_pass", pass, 1'b0);
        check("rst_err", err_count, 8'd0);
        check("rst_ops", {a, b, c_in}, 9'd0);
        rst_n = 1'b1;

        // Golden adder run.
        kick(8'd0);
        wait_idle(100);
`ifdef ADDER_BIST_FIRST_FAIL_EN
        check("fail_valid_clean", fail_valid, 1'b0);
`endif

        // Faulty adder: every vector mismatches.
        fault = 1'b1;
        kick(8'd16);
        wait_idle(100);
`ifdef ADDER_BIST_FIRST_FAIL_EN
        check("fail_valid", fail_valid, 1'b1);
        check("fail_a", fail_a, 4'h1);
        check("fail_b", fail_b, 4'hE);
        check("fail_cin", fail_cin, 1'b0);
`endif
        fault = 1'b0;

        // Extra start pulses while busy must be ignored.
        d0 = done_cnt;
        kick(8'd0);
        repeat (4) @(posedge clk);
        @(negedge clk) start = 1'b1;
        @(posedge clk) #1 start = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk) start = 1'b1;
        @(posedge clk) #1 start = 1'b0;
        wait_idle(100);
        repeat (10) @(negedge clk);
        check("single_done", done_cnt - d0, 32'd1);
        check("no_restart", busy, 1'b0);

        // Synchronous reset mid-run abandons the run.
        d0 = done_cnt;
        kick(8'd0);
        repeat (9) @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_pass", pass, 1'b0);
        check("midrst_err", err_count, 8'd0);
        check("midrst_ops", {a, b, c_in}, 9'd0);
        @(negedge clk) rst_n = 1'b1;
        vq.delete();
        rq.delete();
        pass_pending = 1'b0;
        repeat (40) @(negedge clk);
        check("midrst_no_done", done_cnt - d0, 32'd0);
        kick(8'd0);
        @(negedge clk);
        @(negedge clk);
        check("restart_first_a", a, 4'h1);
        check("restart_first_b", b, 4'hE);
        wait_idle(100);

        // Start held high: back-to-back identical runs, 2N+2 cycles apart.
        d0 = done_cnt;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1;
        n = cyc;
        push_run(n, 8'd0);
        push_run(n + 2 * N + 2, 8'd0);
        repeat (2 * N + 2) @(posedge clk);
        #1 start = 1'b0;
        wait_idle(200);
        check("held_two_done", done_cnt - d0, 32'd2);

        // Long faulty run saturates err_count.
        fault = 1'b1;
        @(negedge clk) start2 = 1'b1;
        @(posedge clk) #1 start2 = 1'b0;
        n = 0;
        while (!done2 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!done2) begin
            check("sat_timeout", 32'd1, 32'd0);
        end else begin
            check("sat_cycles", n, 2 * N2 + 1);
            check("sat_err", err2, 8'd255);
            @(negedge clk);
            check("sat_pass", pass2, 1'b0);
        end
        fault = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
